// File: rtl/random_roller.sv
// random_roller
//   Dice-style random number generator. A free-running 16-bit Fibonacci LFSR
//   is sampled at intervals that grow linearly while rolling; the roll settles
//   after NUM_UPDATES updates or on a stop request. Each settled result goes
//   into a circular history that can be paged through, newest first.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      synchronous active-low reset
//   i_start      start / restart (rising-edge detected)
//   i_stop       stop roll or leave history display (rising-edge detected)
//   i_show       enter / advance history display (rising-edge detected)
//   o_random_out displayed value
//   o_busy       rolling
//   o_valid      settled result on display
//   o_hist_idx   history index shown (0 = newest), 0 outside SHOW
//   o_hist_cnt   number of valid history entries
module random_roller #(
  parameter int          WIDTH       = 4,
  parameter int          HIST_DEPTH  = 4,
  parameter int          INIT_PERIOD = 1,
  parameter int          NUM_UPDATES = 16,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic                          i_stop,
  input  logic                          i_show,
  output logic [WIDTH-1:0]              o_random_out,
  output logic                          o_busy,
  output logic                          o_valid,
  output logic [$clog2(HIST_DEPTH)-1:0] o_hist_idx,
  output logic [$clog2(HIST_DEPTH):0]   o_hist_cnt
);

  localparam int IDX_W = $clog2(HIST_DEPTH);
  // period reaches INIT_PERIOD*(NUM_UPDATES+1) on the final update
  localparam int PER_W = $clog2(INIT_PERIOD * (NUM_UPDATES + 1) + 1);
  localparam int UPD_W = $clog2(NUM_UPDATES + 1);
  localparam logic [IDX_W:0] CNT_ONE = 1;
  localparam logic [IDX_W:0] CNT_MAX = HIST_DEPTH;

  typedef enum logic [1:0] {IDLE, ROLL, DONE, SHOW} state_t;

  state_t           state_q;
  logic             start_q, stop_q, show_q;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [PER_W-1:0] tick_q, period_q;
  logic [UPD_W-1:0] upd_q;
  logic [WIDTH-1:0] out_q;
  logic [IDX_W-1:0] wptr_q, idx_q;
  logic [IDX_W:0]   cnt_q;
  logic [WIDTH-1:0] hist_q [HIST_DEPTH];

  logic             start_e, stop_e, show_e;
  logic             upd_fire, settle;
  logic [WIDTH-1:0] roll_val, newest_val, adv_val;
  logic [IDX_W-1:0] newest_ptr, idx_adv;

  assign start_e = i_start & ~start_q;
  assign stop_e  = i_stop  & ~stop_q;
  assign show_e  = i_show  & ~show_q;

  // taps 16,14,13,11 -> bits 15,13,12,10
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  assign upd_fire = (state_q == ROLL) && (tick_q == period_q - PER_W'(1));
  // value o_random_out takes this edge while rolling; also the history push value
  assign roll_val = upd_fire ? lfsr_q[WIDTH-1:0] : out_q;
  // start has priority over stop and over the automatic settle
  assign settle   = (state_q == ROLL) && !start_e &&
                    (stop_e || (upd_fire && (upd_q == UPD_W'(NUM_UPDATES - 1))));

  assign newest_ptr = wptr_q - IDX_W'(1);
  assign idx_adv    = ({1'b0, idx_q} == cnt_q - CNT_ONE) ? '0 : idx_q + IDX_W'(1);
  assign newest_val = hist_q[newest_ptr];
  assign adv_val    = hist_q[newest_ptr - idx_adv];

  // history storage carries no reset; it is unreadable while cnt is 0
  always_ff @(posedge i_clk) begin
    if (i_rst_n && settle) hist_q[wptr_q] <= roll_val;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      show_q   <= 1'b0;
      lfsr_q   <= SEED;
      tick_q   <= '0;
      period_q <= PER_W'(INIT_PERIOD);
      upd_q    <= '0;
      out_q    <= '0;
      wptr_q   <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
    end else begin
      start_q <= i_start;
      stop_q  <= i_stop;
      show_q  <= i_show;
      lfsr_q  <= lfsr_d;

      if (start_e) begin
        // roll entry from any state; display holds until the first update
        state_q  <= ROLL;
        tick_q   <= '0;
        period_q <= PER_W'(INIT_PERIOD);
        upd_q    <= '0;
        idx_q    <= '0;
      end else begin
        unique case (state_q)
          IDLE: ;
          ROLL: begin
            out_q <= roll_val;
            if (upd_fire) begin
              upd_q    <= upd_q + UPD_W'(1);
              tick_q   <= '0;
              period_q <= period_q + PER_W'(INIT_PERIOD);
            end else begin
              tick_q <= tick_q + PER_W'(1);
            end
            if (settle) begin
              state_q <= DONE;
              wptr_q  <= wptr_q + IDX_W'(1);
              if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_ONE;
            end
          end
          DONE: begin
            if (show_e && cnt_q != '0) begin
              state_q <= SHOW;
              idx_q   <= '0;
              out_q   <= newest_val;
            end
          end
          SHOW: begin
            if (stop_e) begin
              state_q <= DONE;
              idx_q   <= '0;
              out_q   <= newest_val;
            end else if (show_e) begin
              idx_q <= idx_adv;
              out_q <= adv_val;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign o_random_out = out_q;
  assign o_busy       = (state_q == ROLL);
  assign o_valid      = (state_q == DONE);
  assign o_hist_idx   = idx_q;
  assign o_hist_cnt   = cnt_q;

endmodule

// File: tb/tb_random_roller.sv
// Directed bench for random_roller: default instance plus a NUM_UPDATES=64
// instance for the long stop scenario. Expected results come from a reference
// LFSR and are queued at stimulus time, then popped when the DUT shows them.
module tb_random_roller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, stop, show, start64, stop64, show64;
  logic [3:0] out, out64;
  logic       busy, valid, busy64, valid64;
  logic [1:0] idx, idx64;
  logic [2:0] cnt, cnt64;

  random_roller u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_show(show),
    .o_random_out(out), .o_busy(busy), .o_valid(valid),
    .o_hist_idx(idx), .o_hist_cnt(cnt)
  );

  random_roller #(.NUM_UPDATES(64)) u_dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start64), .i_stop(stop64), .i_show(show64),
    .o_random_out(out64), .o_busy(busy64), .o_valid(valid64),
    .o_hist_idx(idx64), .o_hist_cnt(cnt64)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  function automatic logic [15:0] lfsr_adv(input logic [15:0] l, input int n);
    for (int i = 0; i < n; i++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    return l;
  endfunction

  function automatic logic [31:0] exp_at(input logic [15:0] l, input int n);
    logic [15:0] t;
    t = lfsr_adv(l, n);
    return {28'd0, t[3:0]};
  endfunction

  // largest triangular number (update cycle) not beyond s
  function automatic int last_tri(input int s);
    int t, k;
    t = 0; k = 1;
    while (t + k <= s) begin t += k; k++; end
    return t;
  endfunction

  // reference LFSR: between edges it holds the value the DUT uses at the next edge
  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lfsr_adv(m_lfsr, 1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s observed=%0h expected=<scoreboard empty>", tag, obs);
    end else begin
      chk(tag, obs, exp_q.pop_front());
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_out"},   32'(out),   32'd0);
    chk({tag, "_busy"},  32'(busy),  32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_idx"},   32'(idx),   32'd0);
    chk({tag, "_cnt"},   32'(cnt),   32'd0);
  endtask

  // start a roll, stop it s cycles after the start edge
  task automatic roll_stop(input int s, output logic [3:0] v);
    logic [31:0] e;
    e = exp_at(m_lfsr, last_tri(s));
    v = e[3:0];
    exp_q.push_back(e);
    start = 1'b1; step(); start = 1'b0;
    repeat (s - 1) step();
    stop = 1'b1; step(); stop = 1'b0;
    chk("roll_busy", 32'(busy), 32'd0);
    chk("roll_valid", 32'(valid), 32'd1);
    pop_chk("roll_out", 32'(out));
  endtask

  initial begin
    logic [15:0] l0;
    logic [3:0]  res [5];
    logic [3:0]  v;
    int          tri_c[$];
    int          t, k, c, done_c;

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; show = 1'b0;
    start64 = 1'b0; stop64 = 1'b0; show64 = 1'b0;
    repeat (3) step();
    chk_reset("rst");
    chk("rst64_out", 32'(out64), 32'd0);
    chk("rst64_cnt", 32'(cnt64), 32'd0);
    rst_n = 1'b1;
    step();

    // 1: full roll, start held two cycles
    l0 = m_lfsr;
    t = 0;
    for (int j = 1; j <= 16; j++) begin
      t += j;
      tri_c.push_back(t);
      exp_q.push_back(exp_at(l0, t));
    end
    start = 1'b1; step();
    chk("t1_busy_e0", 32'(busy), 32'd1);
    chk("t1_out_hold", 32'(out), 32'd0);
    step(); start = 1'b0;
    k = 0; done_c = -1;
    for (c = 1; c <= 300; c++) begin
      if (k < 16 && c == tri_c[k]) begin
        pop_chk($sformatf("t1_upd%0d", k + 1), 32'(out));
        k++;
      end
      if (valid) begin done_c = c; break; end
      if (!busy) begin done_c = -c; break; end
      step();
    end
    chk("t1_done_cycle", 32'(done_c), 32'd136);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_cnt", 32'(cnt), 32'd1);

    // 2: NUM_UPDATES=64 instance, stop 491 cycles after start
    l0 = m_lfsr;
    exp_q.push_back(exp_at(l0, 465));
    start64 = 1'b1; step(); start64 = 1'b0;
    repeat (490) step();
    chk("t2_busy_pre", 32'(busy64), 32'd1);
    stop64 = 1'b1; step(); stop64 = 1'b0;
    chk("t2_busy", 32'(busy64), 32'd0);
    chk("t2_valid", 32'(valid64), 32'd1);
    pop_chk("t2_out", 32'(out64));
    chk("t2_cnt", 32'(cnt64), 32'd1);

    // 3: five stopped rolls, then page through history
    for (int i = 0; i < 5; i++) begin
      roll_stop(10 * (i + 1), res[i]);
      chk($sformatf("t3_cnt%0d", i), 32'(cnt), (i + 2 > 4) ? 32'd4 : 32'(i + 2));
    end
    exp_q.push_back(32'(res[4])); exp_q.push_back(32'(res[3]));
    exp_q.push_back(32'(res[2])); exp_q.push_back(32'(res[1]));
    exp_q.push_back(32'(res[4])); exp_q.push_back(32'(res[3]));
    for (int i = 0; i < 6; i++) begin
      show = 1'b1; step();
      chk($sformatf("t3_idx%0d", i), 32'(idx), 32'(i % 4));
      pop_chk($sformatf("t3_show%0d", i), 32'(out));
      chk($sformatf("t3_cnt_show%0d", i), 32'(cnt), 32'd4);
      show = 1'b0; step();
    end
    stop = 1'b1; step(); stop = 1'b0;
    chk("t3_exit_valid", 32'(valid), 32'd1);
    chk("t3_exit_out", 32'(out), 32'(res[4]));
    chk("t3_exit_idx", 32'(idx), 32'd0);

    // 4: stop exactly on update 3 (cycle 6)
    roll_stop(6, v);
    chk("t4_cnt", 32'(cnt), 32'd4);
    show = 1'b1; step(); show = 1'b0;
    chk("t4_hist_idx", 32'(idx), 32'd0);
    chk("t4_hist_val", 32'(out), 32'(v));
    step();

    // 5: start+stop together restarts; show during ROLL has no effect
    l0 = m_lfsr;
    start = 1'b1; step(); start = 1'b0;
    chk("t5_busy", 32'(busy), 32'd1);
    chk("t5_idx", 32'(idx), 32'd0);
    step();
    chk("t5_upd1", 32'(out), exp_at(l0, 1));
    step(); step();
    chk("t5_upd2", 32'(out), exp_at(l0, 3));
    l0 = m_lfsr;
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("t5_restart_busy", 32'(busy), 32'd1);
    chk("t5_restart_valid", 32'(valid), 32'd0);
    step();
    chk("t5_restart_upd1", 32'(out), exp_at(l0, 1));
    show = 1'b1; step(); show = 1'b0;
    chk("t5_show_busy", 32'(busy), 32'd1);
    chk("t5_show_out", 32'(out), exp_at(l0, 1));
    chk("t5_show_idx", 32'(idx), 32'd0);
    step();
    chk("t5_upd2b", 32'(out), exp_at(l0, 3));

    // 6: reset mid-roll with two results stored
    rst_n = 1'b0; step(); step(); rst_n = 1'b1; step();
    chk_reset("t6_rst");
    roll_stop(3, v);
    chk("t6_cnt1", 32'(cnt), 32'd1);
    roll_stop(7, v);
    chk("t6_cnt2", 32'(cnt), 32'd2);
    start = 1'b1; step(); start = 1'b0;
    repeat (49) step();
    chk("t6_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0; step();
    chk_reset("t6_midroll");
    rst_n = 1'b1; step();
    show = 1'b1; step(); show = 1'b0;
    chk_reset("t6_show_idle");
    stop = 1'b1; step(); stop = 1'b0;
    chk_reset("t6_stop_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/random_roller.md
# random_roller

Parametrised dice-style random number generator with automatic slow-down, manual stop, and a result history. A free-running 16-bit LFSR is sampled at intervals that lengthen linearly while rolling. Each roll settles either after a fixed number of updates or on a stop request. Each settled result is pushed into a circular history that the user can page through. It sits directly behind the debounced push-button inputs and drives the seven-segment display path in the top level.

## Interface
- WIDTH, 4, output value width; legal range 2..16.
- HIST_DEPTH, 4, number of stored results; power of two, ≥2.
- INIT_PERIOD, 1, cycles before the first update; the period grows by INIT_PERIOD after every update.
- NUM_UPDATES, 16, number of updates after which the roll settles automatically.
- SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_start  in  1  start/restart request, level input, rising-edge detected.
- i_stop  in  1  stop request or show-exit, rising-edge detected.
- i_show  in  1  enter or advance history display, rising-edge detected.
- o_random_out  out  WIDTH  displayed value.
- o_busy  out  1  high in ROLL.
- o_valid  out  1  high in DONE.
- o_hist_idx  out  clog2(HIST_DEPTH)  displayed history index in SHOW, else 0.
- o_hist_cnt  out  clog2(HIST_DEPTH)+1  number of valid history entries.

## Operation
- Edge detect: each of i_start, i_stop and i_show has a registered previous-value flop, reset to 0. An edge is asserted when the input is 1 and its flop is 0. An edge acts at the same clock edge where the input is first sampled high.
- LFSR:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11; the new bit0 is the XOR of those taps.
  - It shifts left every cycle in every state.
  - Sampled value is lfsr[WIDTH-1:0].
- FSM states: IDLE, ROLL, DONE, SHOW. Reset enters IDLE.
- IDLE:
  - start edge → ROLL.
  - stop and show edges are ignored.
- ROLL entry (from any state, including ROLL itself):
  - period = INIT_PERIOD, tick = 0, upd = 0.
  - o_random_out holds its previous value until the first update.
- ROLL, each cycle:
  - tick increments.
  - When tick == period−1 an update fires: o_random_out ← sample, upd+1, tick ← 0, period ← period + INIT_PERIOD.
  - Size the period counter to hold INIT_PERIOD·NUM_UPDATES.
- ROLL exits:
  - The update that makes upd == NUM_UPDATES → DONE.
  - A stop edge → DONE; o_random_out keeps its current value.
  - Stop edge coinciding with an update: the update is applied first, then the block goes to DONE.
  - Start edge in ROLL restarts the roll. Start and stop edges in the same cycle: start wins.
  - Show edges are ignored.
- History push on every ROLL→DONE transition:
  - Written value = the value o_random_out takes at that same edge.
  - Write pointer increments modulo HIST_DEPTH.
  - o_hist_cnt saturates at HIST_DEPTH; the oldest entry is overwritten.
- DONE:
  - start edge → ROLL.
  - show edge with o_hist_cnt > 0 → SHOW, idx = 0.
- SHOW:
  - o_random_out = entry idx, where idx 0 is the newest entry and idx 1 the one before it.
  - show edge: idx ← idx+1, wrapping to 0 after o_hist_cnt−1.
  - stop edge → DONE, o_random_out = newest entry.
  - start edge → ROLL. Start and stop edges together: start wins.
- Reset clears LFSR (to SEED), FSM, counters, history pointer, and count.

## Timing
- Reset values:
  - o_random_out = 0, o_busy = 0, o_valid = 0, o_hist_idx = 0, o_hist_cnt = 0.
  - State IDLE, LFSR = SEED.
  - History RAM contents don't-care, unreadable while count = 0.
- Start latency: o_busy rises at the edge that samples the start edge.
- Update schedule: update k occurs INIT_PERIOD·k·(k+1)/2 cycles after ROLL entry. With defaults the last update is at cycle 136 and o_valid rises at that edge.
- Stop latency: o_busy falls and o_valid rises at the edge that samples the stop edge.
- Show latency: o_random_out and o_hist_idx change at the edge that samples the show edge.
- A held input produces exactly one action; it must be released and re-asserted to act again.
- Reset mid-roll or mid-show: all outputs return to reset values at that edge; no history push occurs.

## Test plan
- Reset, then start held for 2 cycles, no stop → o_busy for 136 cycles, 16 updates at cycles 1,3,6,…,136. o_valid=1 and o_hist_cnt=1, with the final value matching a reference LFSR model from SEED 16'hACE1.
- Start, then stop edge 491 cycles later with NUM_UPDATES=64 → DONE at the stop edge, o_random_out equal to the last update, o_hist_cnt increments.
- Five rolls with stops at 10, 20, 30, 40, 50 cycles, then 6 show edges → o_hist_idx cycles 0,1,2,3,0,1 showing results 5,4,3,2,5,4. o_hist_cnt stays 4. A following stop edge restores result 5.
- Stop edge landing exactly on an update cycle (cycle 6) → o_random_out shows the update-3 sample; history holds that value.
- Start and stop edges in the same cycle during ROLL → roll restarts, with the next update INIT_PERIOD cycles later. Show edge during ROLL → no effect.
- i_rst_n low at cycle 50 of a roll with 2 results stored → all outputs 0, o_hist_cnt=0. A later show edge is ignored in IDLE.
